xgmii_frame_fcs_strip: RTL and testbench

//  Forward-path (ingress) counterpart of the backward-path FCS re-insertion stage: takes a 32-bit XGMII

---
 rtl/xgmii_frame_fcs_strip_pkg.sv | 29 ++
 rtl/xgmii_frame_fcs_strip_if.sv | 24 ++
 rtl/xgmii_frame_fcs_strip_crc32.sv | 28 ++
 rtl/xgmii_frame_fcs_strip.sv | 173 +++++++++++++++++
 tb/tb_xgmii_frame_fcs_strip.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xgmii_frame_fcs_strip_pkg.sv
// Shared XGMII / PLA definitions: control characters, word patterns, CRC32 constants.
package xgmii_frame_fcs_strip_pkg;

    localparam logic [31:0] XGMII_IDLE_WORD = 32'h07070707;
    localparam logic [31:0] XGMII_SFD_WORD  = 32'h555555D5;
    localparam logic [7:0]  XGMII_IDLE      = 8'h07;
    localparam logic [7:0]  XGMII_START     = 8'hFB;
    localparam logic [7:0]  XGMII_TERM      = 8'hFD;
    localparam logic [7:0]  XGMII_ERR       = 8'hFE;

    // TERM txc patterns, named by the number of data bytes that precede FD
    localparam logic [3:0]  TXC_T3    = 4'h1;
    localparam logic [3:0]  TXC_T2    = 4'h3;
    localparam logic [3:0]  TXC_T1    = 4'h7;
    localparam logic [3:0]  TXC_T0    = 4'hf;
    localparam logic [3:0]  TXC_START = 4'h8;
    localparam logic [3:0]  TXC_IDLE  = 4'hf;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    // One 32-bit XGMII word with its control flags and sideband tag
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  txc;
        logic [1:0]  num;
    } xgmii_word_t;

endpackage

// File: rtl/xgmii_frame_fcs_strip_if.sv
// Stream and status bundle of the ingress FCS strip stage.
interface xgmii_frame_fcs_strip_if;
    logic [31:0] I_xgmii_data;
    logic [3:0]  I_xgmii_txc;
    logic [1:0]  I_xgmii_num;
    logic [31:0] O_xgmii_data;
    logic [3:0]  O_xgmii_txc;
    logic [1:0]  O_xgmii_num;
    logic        O_crc_ok;
    logic        O_crc_err;
    logic [31:0] O_crc_out;

    // Upstream side (word aligner) drives the input stream
    modport master (
        output I_xgmii_data, I_xgmii_txc, I_xgmii_num,
        input  O_xgmii_data, O_xgmii_txc, O_xgmii_num, O_crc_ok, O_crc_err, O_crc_out
    );

    // The strip stage itself
    modport slave (
        input  I_xgmii_data, I_xgmii_txc, I_xgmii_num,
        output O_xgmii_data, O_xgmii_txc, O_xgmii_num, O_crc_ok, O_crc_err, O_crc_out
    );
endinterface

// File: rtl/xgmii_frame_fcs_strip_crc32.sv
// Combinational CRC32 next-state over 0..4 bytes of a word, byte [31:24] first.
// Register is kept unreflected; bit 0 of each byte enters first (802.3 wire order).
module crc32_d32_be
    import xgmii_frame_fcs_strip_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [31:0] data_i,
    input  logic [2:0]  nbytes_i,
    output logic [31:0] crc_o
);

    // Bit-serial LFSR unrolled over the enabled leading bytes
    always_comb begin
        logic [31:0] c;
        logic [7:0]  b;
        logic        fb;
        c = crc_i;
        for (int i = 0; i < 4; i++) begin
            b = data_i[31-8*i -: 8];
            for (int k = 0; k < 8; k++) begin
                fb = c[31] ^ b[k];
                if (3'(i) < nbytes_i) c = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
            end
        end
        crc_o = c;
    end

endmodule

// File: rtl/xgmii_frame_fcs_strip.sv
// Ingress FCS strip: checks frame CRC32, pulls /T/ back one word over the FCS,
// and reports crc_ok/crc_err plus the stripped FCS. Fixed 3-cycle latency.
module xgmii_frame_fcs_strip
    import xgmii_frame_fcs_strip_pkg::*;
#(
    parameter int          P_MIN_BYTES   = 5,
    parameter logic [31:0] P_CRC_RESIDUE = CRC32_RESIDUE
) (
    input  logic                    I_312m_clk,
    input  logic                    I_global_rst_n,
    xgmii_frame_fcs_strip_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PRE  = 2'd1;
    localparam logic [1:0] ST_PAY  = 2'd2;
    localparam xgmii_word_t IDLE_W = '{data: XGMII_IDLE_WORD, txc: TXC_IDLE, num: 2'd0};

    xgmii_word_t d1_q, d2_q, out_q;
    logic [1:0]  state_q, state_d;
    logic [31:0] crc_q, crc_d, crc_nxt;
    logic [15:0] cnt_q, cnt_d;
    logic [16:0] cnt_fin;
    logic        kill_q, pend_err_q, crc_ok_q, crc_err_q;
    logic [31:0] crc_out_q;

    logic        is_start, is_term, long_enough, strip, bad_evt, crc_good;
    logic [2:0]  term_n;
    logic [31:0] strip_word, fcs_word;

    // Classify the word in d1
    always_comb begin
        is_start = (d1_q.txc == TXC_START) && (d1_q.data[31:24] == XGMII_START);
        is_term  = 1'b0;
        term_n   = 3'd0;
        case (d1_q.txc)
            TXC_T3:  begin term_n = 3'd3; is_term = (d1_q.data[7:0]   == XGMII_TERM); end
            TXC_T2:  begin term_n = 3'd2; is_term = (d1_q.data[15:8]  == XGMII_TERM); end
            TXC_T1:  begin term_n = 3'd1; is_term = (d1_q.data[23:16] == XGMII_TERM); end
            TXC_T0:  begin term_n = 3'd0; is_term = (d1_q.data[31:24] == XGMII_TERM); end
            default: begin term_n = 3'd0; is_term = 1'b0; end
        endcase
    end

    // A TERM word feeds only its leading data bytes; plain data words feed all four
    crc32_d32_be u_crc (
        .crc_i    (crc_q),
        .data_i   (d1_q.data),
        .nbytes_i (is_term ? term_n : 3'd4),
        .crc_o    (crc_nxt)
    );

    assign cnt_fin     = {1'b0, cnt_q} + {14'd0, term_n};
    assign long_enough = (cnt_fin >= 17'(P_MIN_BYTES));
    assign strip       = (state_q == ST_PAY) && is_term && long_enough;
    assign crc_good    = (crc_nxt == P_CRC_RESIDUE);
    // Any control word that ends a frame without a strip: runt, abort, preamble hit
    assign bad_evt     = (d1_q.txc != 4'h0) && !strip &&
                         ((state_q == ST_PRE) || (state_q == ST_PAY));

    // Rebuild W1 with FD after its leading n bytes; the displaced bytes are the FCS
    always_comb begin
        strip_word = {XGMII_TERM, XGMII_IDLE, XGMII_IDLE, XGMII_IDLE};
        fcs_word   = d2_q.data;
        case (term_n)
            3'd3: begin
                strip_word = {d2_q.data[31:8], XGMII_TERM};
                fcs_word   = {d2_q.data[7:0], d1_q.data[31:8]};
            end
            3'd2: begin
                strip_word = {d2_q.data[31:16], XGMII_TERM, XGMII_IDLE};
                fcs_word   = {d2_q.data[15:0], d1_q.data[31:16]};
            end
            3'd1: begin
                strip_word = {d2_q.data[31:24], XGMII_TERM, XGMII_IDLE, XGMII_IDLE};
                fcs_word   = {d2_q.data[23:0], d1_q.data[31:24]};
            end
            default: begin
                strip_word = {XGMII_TERM, XGMII_IDLE, XGMII_IDLE, XGMII_IDLE};
                fcs_word   = d2_q.data;
            end
        endcase
    end

    // Frame FSM, running CRC and saturating payload byte counter
    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (is_start) state_d = ST_PRE;
            ST_PRE: begin
                if (is_start)                state_d = ST_PRE;
                else if (d1_q.txc != 4'h0)   state_d = ST_IDLE;
                else begin
                    state_d = ST_PAY;
                    crc_d   = 32'hFFFFFFFF;
                    cnt_d   = 16'd0;
                end
            end
            ST_PAY: begin
                if (is_start)                state_d = ST_PRE;
                else if (d1_q.txc != 4'h0)   state_d = ST_IDLE;
                else begin
                    crc_d = crc_nxt;
                    cnt_d = (cnt_q >= 16'hFFFC) ? 16'hFFFF : cnt_q + 16'd4;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Input and hold stages
    always_ff @(posedge I_312m_clk or negedge I_global_rst_n) begin
        if (!I_global_rst_n) begin
            d1_q <= IDLE_W;
            d2_q <= IDLE_W;
        end else begin
            d1_q <= {bus.I_xgmii_data, bus.I_xgmii_txc, bus.I_xgmii_num};
            d2_q <= d1_q;
        end
    end

    // FSM / CRC / counter state
    always_ff @(posedge I_312m_clk or negedge I_global_rst_n) begin
        if (!I_global_rst_n) begin
            state_q <= ST_IDLE;
            crc_q   <= 32'hFFFFFFFF;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output stage: relocated-FD word, then an idle word in place of the original TERM
    always_ff @(posedge I_312m_clk or negedge I_global_rst_n) begin
        if (!I_global_rst_n) begin
            out_q  <= IDLE_W;
            kill_q <= 1'b0;
        end else begin
            kill_q <= strip;
            if (strip)       out_q <= {strip_word, d1_q.txc, d2_q.num};
            else if (kill_q) out_q <= {XGMII_IDLE_WORD, TXC_IDLE, d2_q.num};
            else             out_q <= d2_q;
        end
    end

    // Status: strip verdict lands with the FD word; other errors wait one cycle
    // so they line up with the offending word leaving the hold stage
    always_ff @(posedge I_312m_clk or negedge I_global_rst_n) begin
        if (!I_global_rst_n) begin
            pend_err_q <= 1'b0;
            crc_ok_q   <= 1'b0;
            crc_err_q  <= 1'b0;
            crc_out_q  <= 32'h0;
        end else begin
            pend_err_q <= bad_evt;
            crc_ok_q   <= strip && crc_good;
            crc_err_q  <= (strip && !crc_good) || pend_err_q;
            if (strip) crc_out_q <= fcs_word;
        end
    end

    assign bus.O_xgmii_data = out_q.data;
    assign bus.O_xgmii_txc  = out_q.txc;
    assign bus.O_xgmii_num  = out_q.num;
    assign bus.O_crc_ok     = crc_ok_q;
    assign bus.O_crc_err    = crc_err_q;
    assign bus.O_crc_out    = crc_out_q;

endmodule

// File: tb/tb_xgmii_frame_fcs_strip.sv
// Randomized bench for xgmii_frame_fcs_strip against a frame-level byte model.
module tb_xgmii_frame_fcs_strip;
    import xgmii_frame_fcs_strip_pkg::*;

    localparam int MINB = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    xgmii_frame_fcs_strip_if ifc();

    xgmii_frame_fcs_strip dut (
        .I_312m_clk     (clk),
        .I_global_rst_n (rst_n),
        .bus            (ifc.slave)
    );

    xgmii_word_t stim[$];
    logic [31:0] exp_d[$];
    logic [3:0]  exp_c[$];
    logic [1:0]  exp_n[$];
    logic        exp_ok[$];
    logic        exp_err[$];
    logic [31:0] exp_crc[$];
    logic [7:0]  pq[$];
    logic [31:0] crc_held;
    int          n_chk = 0;
    int          n_pass = 0;

    function automatic logic [7:0] lane(input logic [31:0] w, input int l);
        logic [31:0] t;
        t = w >> (24 - 8 * l);
        return t[7:0];
    endfunction

    // Reflected (LSB-first) CRC-32 over pq[0..len-1], returns the FCS value
    function automatic logic [31:0] crc_of(input int len);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) begin
            c = c ^ {24'h0, pq[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bit is_start_w(input xgmii_word_t w);
        return (w.txc == 4'h8) && (lane(w.data, 0) == XGMII_START);
    endfunction

    // Number of data lanes before FD in a terminate word, or -1
    function automatic int term_lanes(input xgmii_word_t w);
        int f;
        f = -1;
        for (int l = 0; l < 4; l++) if (f < 0 && w.txc[3-l]) f = l;
        if (f < 0) return -1;
        for (int l = f; l < 4; l++) if (!w.txc[3-l]) return -1;
        if (lane(w.data, f) != XGMII_TERM) return -1;
        return f;
    endfunction

    task automatic add_word(input logic [31:0] d, input logic [3:0] c);
        stim.push_back({d, c, 2'($urandom_range(0, 3))});
    endtask

    // Frame: START, SFD, payload + FCS (optional single bit flip in payload), TERM, gap idles
    task automatic add_frame(input int plen, input int flip, input int gap);
        logic [31:0] fcs, w;
        logic [3:0]  c;
        logic [7:0]  m;
        int pos, r;
        pq.delete();
        for (int i = 0; i < plen; i++) pq.push_back(8'($urandom));
        fcs = crc_of(plen);
        for (int i = 0; i < 4; i++) begin w = fcs >> (8 * i); pq.push_back(w[7:0]); end
        if (flip >= 0) begin
            m = 8'h00; m[flip % 8] = 1'b1;
            pq[flip / 8] = pq[flip / 8] ^ m;
        end
        add_word({XGMII_START, 24'h555555}, TXC_START);
        add_word(XGMII_SFD_WORD, 4'h0);
        pos = 0;
        while (pq.size() - pos >= 4) begin
            add_word({pq[pos], pq[pos+1], pq[pos+2], pq[pos+3]}, 4'h0);
            pos += 4;
        end
        r = pq.size() - pos;
        w = 32'h0; c = 4'h0;
        for (int l = 0; l < 4; l++) begin
            w = w << 8; c = c << 1;
            if (l < r) w[7:0] = pq[pos+l];
            else begin w[7:0] = (l == r) ? XGMII_TERM : XGMII_IDLE; c[0] = 1'b1; end
        end
        add_word(w, c);
        for (int g = 0; g < gap; g++) add_word(XGMII_IDLE_WORD, 4'hf);
    endtask

    // Expected output stream: input copied, then each frame judged from its byte content
    task automatic model();
        int N, i, j, k, n, L, p, ix;
        logic [7:0]  bd[8], nd[8];
        logic        bc[8], nc[8];
        logic        setc[$];
        logic [31:0] cval[$];
        logic [31:0] cur, rx;
        logic        good;
        N = stim.size();
        exp_d.delete(); exp_c.delete(); exp_n.delete();
        exp_ok.delete(); exp_err.delete(); exp_crc.delete();
        for (int x = 0; x < N; x++) begin
            exp_d.push_back(stim[x].data); exp_c.push_back(stim[x].txc); exp_n.push_back(stim[x].num);
            exp_ok.push_back(1'b0); exp_err.push_back(1'b0); setc.push_back(1'b0); cval.push_back(32'h0);
        end
        i = 0;
        while (i < N) begin
            if (!is_start_w(stim[i])) begin i++; continue; end
            j = i + 1;
            if (j >= N) break;
            if (stim[j].txc != 4'h0) begin
                exp_err[j] = 1'b1;
                i = is_start_w(stim[j]) ? j : j + 1;
                continue;
            end
            pq.delete();
            k = j + 1;
            while (k < N && stim[k].txc == 4'h0) begin
                for (int l = 0; l < 4; l++) pq.push_back(lane(stim[k].data, l));
                k++;
            end
            if (k >= N) break;
            if (is_start_w(stim[k])) begin exp_err[k] = 1'b1; i = k; continue; end
            n = term_lanes(stim[k]);
            if (n < 0) begin exp_err[k] = 1'b1; i = k + 1; continue; end
            for (int l = 0; l < n; l++) pq.push_back(lane(stim[k].data, l));
            L = pq.size();
            if (L < MINB) begin exp_err[k] = 1'b1; i = k + 1; continue; end
            rx = {pq[L-1], pq[L-2], pq[L-3], pq[L-4]};
            good = (crc_of(L - 4) == rx);
            exp_ok[k-1] = good; exp_err[k-1] = !good;
            setc[k-1] = 1'b1; cval[k-1] = {pq[L-4], pq[L-3], pq[L-2], pq[L-1]};
            // drop the 4 bytes in front of FD across the two words, pad with idles
            for (int l = 0; l < 4; l++) begin
                bd[l] = lane(stim[k-1].data, l); bc[l] = stim[k-1].txc[3-l];
                bd[4+l] = lane(stim[k].data, l); bc[4+l] = stim[k].txc[3-l];
            end
            p = 4 + n; ix = 0;
            for (int x = 0; x < 8; x++) if (x < n || x >= p) begin nd[ix] = bd[x]; nc[ix] = bc[x]; ix++; end
            while (ix < 8) begin nd[ix] = XGMII_IDLE; nc[ix] = 1'b1; ix++; end
            exp_d[k-1] = {nd[0], nd[1], nd[2], nd[3]}; exp_c[k-1] = {nc[0], nc[1], nc[2], nc[3]};
            exp_d[k]   = {nd[4], nd[5], nd[6], nd[7]}; exp_c[k]   = {nc[4], nc[5], nc[6], nc[7]};
            i = k + 1;
        end
        cur = crc_held;
        for (int x = 0; x < N; x++) begin
            if (setc[x]) cur = cval[x];
            exp_crc.push_back(cur);
        end
        crc_held = cur;
    endtask

    task automatic drive(input xgmii_word_t w);
        ifc.I_xgmii_data = w.data;
        ifc.I_xgmii_txc  = w.txc;
        ifc.I_xgmii_num  = w.num;
    endtask

    task automatic drive_idle();
        drive('{data: XGMII_IDLE_WORD, txc: 4'hf, num: 2'd0});
    endtask

    // Play stim and compare every output word against the model (3 register stages)
    task automatic run(input string name);
        int N, idx;
        model();
        N = stim.size();
        for (int t = 0; t < N + 2; t++) begin
            if (t < N) drive(stim[t]); else drive_idle();
            @(posedge clk); #1;
            if (t >= 2) begin
                idx = t - 2;
                n_chk++; if (ifc.O_xgmii_data !== exp_d[idx]) $display("FAIL %s data[%0d] got %h exp %h", name, idx, ifc.O_xgmii_data, exp_d[idx]); else n_pass++;
                n_chk++; if (ifc.O_xgmii_txc !== exp_c[idx]) $display("FAIL %s txc[%0d] got %h exp %h", name, idx, ifc.O_xgmii_txc, exp_c[idx]); else n_pass++;
                n_chk++; if (ifc.O_xgmii_num !== exp_n[idx]) $display("FAIL %s num[%0d] got %h exp %h", name, idx, ifc.O_xgmii_num, exp_n[idx]); else n_pass++;
                n_chk++; if (ifc.O_crc_ok !== exp_ok[idx]) $display("FAIL %s crc_ok[%0d] got %b exp %b", name, idx, ifc.O_crc_ok, exp_ok[idx]); else n_pass++;
                n_chk++; if (ifc.O_crc_err !== exp_err[idx]) $display("FAIL %s crc_err[%0d] got %b exp %b", name, idx, ifc.O_crc_err, exp_err[idx]); else n_pass++;
                n_chk++; if (ifc.O_crc_out !== exp_crc[idx]) $display("FAIL %s crc_out[%0d] got %h exp %h", name, idx, ifc.O_crc_out, exp_crc[idx]); else n_pass++;
            end
        end
        stim.delete();
    endtask

    task automatic test_reset();
        drive_idle();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (ifc.O_xgmii_data !== 32'h07070707) $display("FAIL reset data got %h exp 07070707", ifc.O_xgmii_data); else n_pass++;
        n_chk++; if (ifc.O_xgmii_txc !== 4'hf) $display("FAIL reset txc got %h exp f", ifc.O_xgmii_txc); else n_pass++;
        n_chk++; if (ifc.O_xgmii_num !== 2'd0) $display("FAIL reset num got %h exp 0", ifc.O_xgmii_num); else n_pass++;
        n_chk++; if (ifc.O_crc_ok !== 1'b0) $display("FAIL reset crc_ok got %b exp 0", ifc.O_crc_ok); else n_pass++;
        n_chk++; if (ifc.O_crc_err !== 1'b0) $display("FAIL reset crc_err got %b exp 0", ifc.O_crc_err); else n_pass++;
        n_chk++; if (ifc.O_crc_out !== 32'h0) $display("FAIL reset crc_out got %h exp 0", ifc.O_crc_out); else n_pass++;
        rst_n = 1'b1;
        crc_held = 32'h0;
    endtask

    // All four TERM lane positions
    task automatic test_good_frames();
        for (int p = 59; p <= 62; p++) add_frame(p, -1, 2);
        run("good");
    endtask

    task automatic test_bad_crc();
        add_frame(60, $urandom_range(0, 60 * 8 - 1), 2);
        add_frame(61, -1, 1);
        run("badcrc");
    endtask

    task automatic test_error_word();
        xgmii_word_t w;
        int s;
        s = stim.size();
        add_frame(40, -1, 2);
        w = stim[s+5];
        w.data[23:16] = XGMII_ERR;
        w.txc = 4'h4;
        stim[s+5] = w;
        add_frame(33, -1, 2);
        run("errword");
    endtask

    // Short TERM with back-to-back START, TERM in preamble slot, zero-length payload
    task automatic test_runt();
        add_word({XGMII_START, 24'h555555}, TXC_START);
        add_word(XGMII_SFD_WORD, 4'h0);
        add_word({8'($urandom), 8'($urandom), XGMII_TERM, XGMII_IDLE}, 4'h3);
        add_frame(61, -1, 1);
        add_word({XGMII_START, 24'h555555}, TXC_START);
        add_word({XGMII_TERM, 24'h070707}, 4'hf);
        add_word(XGMII_IDLE_WORD, 4'hf);
        add_frame(0, -1, 1);
        add_frame(1, -1, 2);
        run("runt");
    endtask

    task automatic test_back_to_back();
        int plen, gap;
        for (int f = 0; f < 8; f++) begin
            plen = $urandom_range(0, 70);
            gap = ((plen % 4) == 0) ? $urandom_range(1, 2) : $urandom_range(0, 2);
            add_frame(plen, ($urandom_range(0, 3) == 0 && plen > 0) ? $urandom_range(0, plen * 8 - 1) : -1, gap);
        end
        add_word({XGMII_START, 24'h555555}, TXC_START);
        add_word(XGMII_SFD_WORD, 4'h0);
        add_word(32'($urandom), 4'h0);
        add_frame(20, -1, 2);
        run("b2b");
    endtask

    task automatic test_reset_midframe();
        add_frame(60, -1, 0);
        for (int t = 0; t < 9; t++) begin
            drive(stim[t]);
            @(posedge clk);
        end
        stim.delete();
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (ifc.O_xgmii_data !== 32'h07070707) $display("FAIL rstmid data got %h exp 07070707", ifc.O_xgmii_data); else n_pass++;
        n_chk++; if (ifc.O_xgmii_txc !== 4'hf) $display("FAIL rstmid txc got %h exp f", ifc.O_xgmii_txc); else n_pass++;
        n_chk++; if (ifc.O_xgmii_num !== 2'd0) $display("FAIL rstmid num got %h exp 0", ifc.O_xgmii_num); else n_pass++;
        n_chk++; if (ifc.O_crc_out !== 32'h0) $display("FAIL rstmid crc_out got %h exp 0", ifc.O_crc_out); else n_pass++;
        drive_idle();
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1;
            n_chk++; if (ifc.O_crc_ok !== 1'b0 || ifc.O_crc_err !== 1'b0) $display("FAIL rstmid flags got %b%b exp 00", ifc.O_crc_ok, ifc.O_crc_err); else n_pass++;
        end
        rst_n = 1'b1;
        crc_held = 32'h0;
        add_frame(60, -1, 2);
        run("after_rst");
    endtask

    initial begin
        crc_held = 32'h0;
        test_reset();
        test_good_frames();
        test_bad_crc();
        test_error_word();
        test_runt();
        test_back_to_back();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
